// File: rtl/result_pkg.sv
// Shared constants, state encoding and helpers for the result frame writer.
// Contents:
//   ADDR_W, DATA_W, LEN_W, MAX_LEN  default widths / largest accepted frame
//   SLOT_STRIDE                     byte distance between result slots
//   writer_state_t                  writer FSM states
//   be_for_tail()                   byte enable for the last halfword of a frame
package result_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned LEN_W   = 11;
  localparam int unsigned MAX_LEN = 1518;

  localparam logic [31:0] SLOT_STRIDE = 32'h0000_060E;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DONE
  } writer_state_t;

  // An odd byte count leaves only the low byte valid in the final halfword.
  function automatic logic [1:0] be_for_tail(input logic [LEN_W-1:0] len);
    return ((len & LEN_W'(1)) != '0) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/result_frame_writer.sv
// Result frame writer: on each write_enable pulse it latches a slot base address and a
// (clamped) frame length, then drains the frame's halfwords from a first-word-fall-through
// capture FIFO into result SRAM via a simple write master with waitrequest back-pressure.
//
// Optional feature: define RESULT_FRAME_WRITER_HEADER_EN to prepend one header word
// ({zeros, len}) at the slot base; frame data then starts at base+2.
//
// Ports:
//   clk, n_rst            clock, synchronous active-low reset
//   write_enable          one-cycle start pulse; addr_in/len_in valid with it
//   addr_in, len_in       slot base byte address, frame length in bytes
//   fifo_rdata/empty/rd   capture FIFO head, empty flag, pop strobe
//   mem_addr/wdata/be     write byte address, data, byte enables (bit0 = low byte)
//   mem_write             write request; accepted when mem_write && !mem_waitrequest
//   mem_waitrequest       memory stall
//   busy                  frame in progress
//   done                  pulse when the last write of a frame is accepted
//   drop_err              pulse after a write_enable that arrived while busy
//   len_err               pulse after a frame longer than MAX_LEN was clamped
module result_frame_writer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  write_enable,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [LEN_W-1:0]      len_in,
  input  logic [DATA_W-1:0]     fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic                  mem_write,
  input  logic                  mem_waitrequest,
  output logic                  busy,
  output logic                  done,
  output logic                  drop_err,
  output logic                  len_err
);
  import result_pkg::*;

  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);

  writer_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              drop_err_q, drop_err_d;
  logic              len_err_q, len_err_d;

  logic              clamp;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  words_new;
  logic              accept;

  assign clamp       = len_in > MaxLenW;
  assign len_clamped = clamp ? MaxLenW : len_in;
  assign words_new   = (len_clamped + LEN_W'(1)) >> 1;
  assign accept      = mem_write && !mem_waitrequest;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    drop_err_d   = 1'b0;
    len_err_d    = 1'b0;
    fifo_rd      = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    done         = 1'b0;

    // Any start request outside IDLE is rejected without touching base/len.
    if (write_enable && (state_q != IDLE)) begin
      drop_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (write_enable) begin
          base_d       = addr_in;
          len_d        = len_clamped;
          len_err_d    = clamp;
          words_left_d = words_new;
`ifdef RESULT_FRAME_WRITER_HEADER_EN
          idx_d        = LEN_W'(1);  // data follows the header word
          state_d      = HDR;
`else
          idx_d        = '0;
          state_d      = (words_new == '0) ? DONE : DATA;
`endif
        end
      end

      HDR: begin
        mem_write = 1'b1;
        mem_addr  = base_q;
        mem_wdata = DATA_W'(len_q);
        mem_be    = '1;
        if (accept) begin
          state_d = (words_left_q == '0) ? DONE : DATA;
        end
      end

      DATA: begin
        mem_write = !fifo_empty;
        mem_addr  = base_q + (ADDR_W'(idx_q) << 1);
        mem_wdata = fifo_rdata;
        mem_be    = (words_left_q == LEN_W'(1)) ? be_for_tail(len_q) : '1;
        if (accept) begin
          fifo_rd      = 1'b1;
          idx_d        = idx_q + LEN_W'(1);
          words_left_d = words_left_q - LEN_W'(1);
          if (words_left_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      drop_err_q   <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      drop_err_q   <= drop_err_d;
      len_err_q    <= len_err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign drop_err = drop_err_q;
  assign len_err  = len_err_q;

endmodule
